lsu_ram_master: RTL and testbench

Load/store initiator that drives the simulation RAM port (`raddr`/`rdata`/`waddr`/`wdata`/`wstrb`/`wen`) from the core's memory stage. It accepts one request at a time over a valid/ready handshake. For each request it builds the doubleword-aligned address, the byte strobe and the shifted write data. For loads it extracts the addressed bytes from the returned doubleword and sign- or zero-extends them before returning a response.

---
 rtl/lsu_pkg.sv | 30 +++
 rtl/lsu_load_align.sv | 31 +++
 rtl/lsu_ram_master.sv | 131 +++++++++++++
 tb/tb_lsu_ram_master.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the load/store RAM master: size codes, FSM states
// and the byte-strobe base mask.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    RADDR,
    RDATA,
    WR,
    RESP
  } state_t;

  function automatic logic [7:0] base_mask(input logic [1:0] size);
    logic [7:0] m;
    m = 8'hFF;
    unique case (size)
      SZ_B: m = 8'h01;
      SZ_H: m = 8'h03;
      SZ_W: m = 8'h0F;
      SZ_D: m = 8'hFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Shift a returned doubleword down to the addressed byte lane and
// sign- or zero-extend it to 64 bits.
import lsu_pkg::*;

module lsu_load_align (
  input  logic [63:0] rdata,
  input  logic [2:0]  off,
  input  logic [1:0]  size,
  input  logic        zext,
  output logic [63:0] data
);

  logic [63:0] sh;

  // Upper lanes fill with zero, so a truncated access reads 0 there
  assign sh = rdata >> {off, 3'b000};

  always_comb begin
    data = sh;
    unique case (size)
      SZ_B: data = zext ? {56'b0, sh[7:0]}
                        : {{56{sh[7]}}, sh[7:0]};
      SZ_H: data = zext ? {48'b0, sh[15:0]}
                        : {{48{sh[15]}}, sh[15:0]};
      SZ_W: data = zext ? {32'b0, sh[31:0]}
                        : {{32{sh[31]}}, sh[31:0]};
      SZ_D: data = sh;
    endcase
  end

endmodule

// File: rtl/lsu_ram_master.sv
// Load/store initiator for the simulation RAM port, one request at a time.
// Define LSU_MISALIGN_CHECK_EN to reject misaligned requests with resp_err.
import lsu_pkg::*;

module lsu_ram_master #(
  parameter int ADDR_W = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [63:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [63:0]       ram_rdata,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [63:0]       ram_wdata,
  output logic [7:0]        ram_wstrb,
  output logic              ram_wen
);

  state_t            state;
  state_t            next;
  logic [2:0]        off;
  logic [1:0]        size_q;
  logic              zext_q;
  logic [63:0]       ld_data;
  logic [7:0]        strb;
  logic [ADDR_W-1:0] aligned;
  logic              accept;
  logic              go_mem;

  assign accept  = (state == IDLE) && req_valid;
  assign aligned = {req_addr[ADDR_W-1:3], 3'b000};
  assign strb    = base_mask(size_q) << off;

`ifdef LSU_MISALIGN_CHECK_EN
  logic misal;
  logic err_q;

  // Low-address bits that must be zero for the given size
  assign misal  = |(req_addr[2:0] & (3'b111 >> (2'd3 - req_size)));
  assign go_mem = ~misal;

  always_ff @(posedge clock) begin
    if (reset) err_q <= 1'b0;
    else if (accept) err_q <= misal;
  end

  assign resp_err = err_q;
`else
  assign go_mem   = 1'b1;
  assign resp_err = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE:
        if (req_valid)
          next = !go_mem ? RESP : (req_wen ? WR : RADDR);
      RADDR: next = RDATA;
      RDATA: next = RESP;
      WR:    next = RESP;
      RESP:  if (resp_ready) next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    ram_wen    = 1'b0;
    ram_wstrb  = 8'h00;
    unique case (1'b1)
      (state == IDLE): req_ready = ~reset;
      (state == WR): begin
        ram_wen   = ~reset;
        ram_wstrb = reset ? 8'h00 : strb;
      end
      (state == RESP): resp_valid = ~reset;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      off        <= '0;
      size_q     <= SZ_B;
      zext_q     <= 1'b0;
      ram_raddr  <= '0;
      ram_waddr  <= '0;
      ram_wdata  <= '0;
      resp_rdata <= '0;
    end else begin
      if (accept) begin
        off        <= req_addr[2:0];
        size_q     <= req_size;
        zext_q     <= req_unsigned;
        resp_rdata <= '0;
        if (go_mem && req_wen) begin
          ram_waddr <= aligned;
          ram_wdata <= req_wdata << {req_addr[2:0], 3'b000};
        end
        if (go_mem && !req_wen) ram_raddr <= aligned;
      end
      if (state == RDATA) resp_rdata <= ld_data;
    end
  end

  lsu_load_align u_align (
    .rdata (ram_rdata),
    .off   (off),
    .size  (size_q),
    .zext  (zext_q),
    .data  (ld_data)
  );

endmodule

// File: tb/tb_lsu_ram_master.sv
// Scoreboard bench for lsu_ram_master with a one-cycle-latency RAM model.
// Expected responses and writes are queued at issue and checked by monitors.
module tb_lsu_ram_master;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic [63:0] ram_raddr;
  logic [63:0] ram_rdata;
  logic [63:0] ram_waddr;
  logic [63:0] ram_wdata;
  logic [7:0]  ram_wstrb;
  logic        ram_wen;
  logic        mem_clr;

  int vectors = 0;
  int miscompares = 0;

  logic [64:0]  exp_q[$];
  logic [135:0] wexp_q[$];
  logic [63:0]  mem[0:15];

  always #5 clock = ~clock;

  lsu_ram_master #(.ADDR_W(64)) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_wen      (req_wen),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .ram_raddr    (ram_raddr),
    .ram_rdata    (ram_rdata),
    .ram_waddr    (ram_waddr),
    .ram_wdata    (ram_wdata),
    .ram_wstrb    (ram_wstrb),
    .ram_wen      (ram_wen)
  );

  always @(posedge clock) begin
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else if (ram_wen) begin
      for (int i = 0; i < 8; i++)
        if (ram_wstrb[i])
          mem[ram_waddr[6:3]][8*i +: 8] <= ram_wdata[8*i +: 8];
    end
    ram_rdata <= mem[ram_raddr[6:3]];
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", 64'(resp_valid), 64'd0);
      end else begin
        logic [64:0] e;
        e = exp_q.pop_front();
        chk("resp_rdata", resp_rdata, e[63:0]);
        chk("resp_err", 64'(resp_err), 64'(e[64]));
      end
    end
  end

  always @(negedge clock) begin
    if (ram_wen) begin
      if (wexp_q.size() == 0) begin
        chk("unexpected_write", 64'(ram_wen), 64'd0);
      end else begin
        logic [135:0] w;
        logic [63:0]  m;
        w = wexp_q.pop_front();
        for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{ram_wstrb[i]}};
        chk("ram_waddr", ram_waddr, w[135:72]);
        chk("ram_wstrb", 64'(ram_wstrb), 64'(w[71:64]));
        chk("ram_wdata", ram_wdata & m, w[63:0]);
      end
    end
  end

  task automatic issue(input logic w, input logic [63:0] a,
                       input logic [63:0] d, input logic [1:0] sz,
                       input logic u, input logic [63:0] er,
                       input logic ee, input int lat, input logic hw,
                       input logic [7:0] ws, input logic [63:0] wd);
    int n;
    req_wen = w;
    req_addr = a;
    req_wdata = d;
    req_size = sz;
    req_unsigned = u;
    req_valid = 1'b1;
    exp_q.push_back({ee, er});
    if (hw) wexp_q.push_back({{a[63:3], 3'b000}, ws, wd});
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    n = 1;
    while (!resp_valid && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("latency", 64'(n), 64'(lat));
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic ld(input logic [63:0] a, input logic [1:0] sz,
                    input logic u, input logic [63:0] er);
    issue(1'b0, a, 64'h0, sz, u, er, 1'b0, 3, 1'b0, 8'h00, 64'h0);
  endtask

  task automatic st(input logic [63:0] a, input logic [63:0] d,
                    input logic [1:0] sz, input logic [7:0] ws,
                    input logic [63:0] wd);
    issue(1'b1, a, d, sz, 1'b0, 64'h0, 1'b0, 2, 1'b1, ws, wd);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] keep;
    int n;
    reset = 1'b1;
    mem_clr = 1'b1;
    req_valid = 1'b0;
    req_wen = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    req_size = 2'd0;
    req_unsigned = 1'b0;
    resp_ready = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_ram_wen", 64'(ram_wen), 64'd0);
    chk("rst_resp_rdata", resp_rdata, 64'd0);
    chk("rst_ram_raddr", ram_raddr, 64'd0);
    chk("rst_ram_wstrb", 64'(ram_wstrb), 64'd0);
    reset = 1'b0;
    mem_clr = 1'b0;
    @(negedge clock);
    chk("idle_req_ready", 64'(req_ready), 64'd1);

    st(64'h8000_0000, 64'h1122334455667788, 2'd3,
       8'hFF, 64'h1122334455667788);
    st(64'h8000_0005, 64'h0000_0000_0000_00AB, 2'd0,
       8'h20, 64'h0000_AB00_0000_0000);
    ld(64'h8000_0000, 2'd3, 1'b0, 64'h1122AB4455667788);
    ld(64'h8000_0005, 2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFAB);
    ld(64'h8000_0005, 2'd0, 1'b1, 64'h0000_0000_0000_00AB);
    ld(64'h8000_0006, 2'd1, 1'b1, 64'h0000_0000_0000_1122);
    ld(64'h8000_0004, 2'd1, 1'b0, 64'hFFFF_FFFF_FFFF_AB44);
    ld(64'h8000_0000, 2'd2, 1'b0, 64'h0000_0000_5566_7788);
`ifdef LSU_MISALIGN_CHECK_EN
    issue(1'b0, 64'h8000_0006, 64'h0, 2'd2, 1'b0,
          64'h0, 1'b1, 1, 1'b0, 8'h00, 64'h0);
`else
    ld(64'h8000_0006, 2'd2, 1'b0, 64'h0000_0000_0000_1122);
`endif
    st(64'h8000_0000, 64'h8000_0001_0000_0000, 2'd3,
       8'hFF, 64'h8000_0001_0000_0000);
    ld(64'h8000_0004, 2'd2, 1'b0, 64'hFFFF_FFFF_8000_0001);
    ld(64'h8000_0004, 2'd2, 1'b1, 64'h0000_0000_8000_0001);
`ifdef LSU_MISALIGN_CHECK_EN
    issue(1'b1, 64'h8000_0003, 64'hBEEF, 2'd1, 1'b0,
          64'h0, 1'b1, 1, 1'b0, 8'h00, 64'h0);
    keep = 64'h8000_0001_0000_0000;
`else
    st(64'h8000_0003, 64'hBEEF, 2'd1, 8'h18, 64'h0000_00BE_EF00_0000);
    keep = 64'h8000_00BE_EF00_0000;
`endif

    // Back-pressured load: response must hold until accepted
    resp_ready = 1'b0;
    req_wen = 1'b0;
    req_addr = 64'h8000_0000;
    req_size = 2'd3;
    req_unsigned = 1'b0;
    req_valid = 1'b1;
    exp_q.push_back({1'b0, keep});
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    n = 1;
    while (!resp_valid && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("stall_latency", 64'(n), 64'd3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("stall_resp_valid", 64'(resp_valid), 64'd1);
      chk("stall_resp_rdata", resp_rdata, keep);
      chk("stall_req_ready", 64'(req_ready), 64'd0);
    end
    @(posedge clock);
    #1 resp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("release_resp_valid", 64'(resp_valid), 64'd0);
    chk("release_req_ready", 64'(req_ready), 64'd1);

    // Reset lands while the store is in WR: nothing may commit
    req_wen = 1'b1;
    req_addr = 64'h8000_0000;
    req_wdata = 64'hDEAD_BEEF_CAFE_F00D;
    req_size = 2'd3;
    req_valid = 1'b1;
    @(posedge clock);
    #1 reset = 1'b1;
    req_valid = 1'b0;
    @(negedge clock);
    chk("wr_rst_ram_wen", 64'(ram_wen), 64'd0);
    chk("wr_rst_ram_wstrb", 64'(ram_wstrb), 64'd0);
    @(posedge clock);
    @(negedge clock);
    chk("post_rst_waddr", ram_waddr, 64'd0);
    chk("post_rst_wdata", ram_wdata, 64'd0);
    chk("post_rst_raddr", ram_raddr, 64'd0);
    chk("post_rst_rdata", resp_rdata, 64'd0);
    chk("post_rst_err", 64'(resp_err), 64'd0);
    chk("post_rst_resp_valid", 64'(resp_valid), 64'd0);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clock);
      chk("no_resp_after_rst", 64'(resp_valid), 64'd0);
    end
    ld(64'h8000_0000, 2'd3, 1'b0, keep);

    repeat (2) @(negedge clock);
    chk("resp_queue_drained", 64'(exp_q.size()), 64'd0);
    chk("write_queue_drained", 64'(wexp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
